rcv_ctrl: RTL and testbench
===========================

RCV_CTRL -- requirements
Module: rcv_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64, maximum data bytes per packet after the PID, range 1..127.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have clk, input, 1 bit, rising-edge system clock.
REQ-004 SHALL have rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have d_edge, input, 1 bit, one-cycle pulse on a detected bus data transition.
REQ-006 SHALL have eop, input, 1 bit, end-of-packet line condition, level.
REQ-007 SHALL have shift_enable, input, 1 bit, one-cycle bit-sample strobe from the bit timer.
REQ-008 SHALL have byte_received, input, 1 bit, one-cycle strobe: 8 bits have been shifted in.
REQ-009 SHALL have rcv_data, input, 8 bits, shifted byte, valid while byte_received=1.
REQ-010 SHALL have rcving, output, 1 bit, packet reception in progress (enables the bit timer).
REQ-011 SHALL have w_enable, output, 1 bit, one-cycle write strobe to the RX FIFO for rcv_data.
REQ-012 SHALL have r_error, output, 1 bit, sticky receive-error flag.
REQ-013 SHALL have pid, output, 4 bits, last accepted PID.
REQ-014 SHALL have byte_cnt, output, 7 bits, data bytes written in the current packet.

Function
REQ-015 SHALL be a Moore FSM with registered outputs; states: IDLE, SYNC_WAIT, CHK_SYNC, PID_WAIT, CHK_PID, RCV_BYTE, STORE, EOP_WAIT, ERR_WAIT, ERR_EOP, ERR_IDLE.
REQ-016 IDLE: rcving=0. d_edge -> SYNC_WAIT. Clear byte_cnt on entry to SYNC_WAIT.
REQ-017 SYNC_WAIT: byte_received -> CHK_SYNC. eop&shift_enable -> ERR_EOP.
REQ-018 CHK_SYNC: rcv_data sampled at byte_received equal to SYNC_BYTE (8'h80) -> PID_WAIT. Any other value -> ERR_WAIT.
REQ-019 PID_WAIT: byte_received -> CHK_PID. eop&shift_enable -> ERR_EOP.
REQ-020 CHK_PID: rcv_data[3:0] == ~rcv_data[7:4] -> latch pid=rcv_data[3:0], go to RCV_BYTE. Otherwise -> ERR_WAIT.
REQ-021 RCV_BYTE: byte_received -> STORE. eop&shift_enable with zero bits pending since the last byte -> EOP_WAIT. eop&shift_enable with bits pending -> ERR_EOP.
REQ-022 SHALL track pending bits with one flag: set on shift_enable, cleared on byte_received; byte_received wins if both occur in the same cycle.
REQ-023 STORE lasts exactly one cycle with w_enable=1, byte_cnt+1, then -> RCV_BYTE. w_enable latency is byte_received+1 cycle.
REQ-024 A byte_received while byte_cnt==MAX_BYTES SHALL go to ERR_WAIT with no w_enable.
REQ-025 EOP_WAIT: rcving=1. d_edge -> IDLE.
REQ-026 ERR_WAIT: r_error=1, rcving=1. eop&shift_enable -> ERR_EOP.
REQ-027 ERR_EOP: r_error=1. d_edge -> ERR_IDLE.
REQ-028 ERR_IDLE: rcving=0, r_error=1. d_edge -> SYNC_WAIT; r_error clears on that transition.
REQ-029 rcving SHALL be 1 in every state except IDLE and ERR_IDLE.
REQ-030 d_edge SHALL be ignored in states other than IDLE, EOP_WAIT, ERR_EOP and ERR_IDLE.
REQ-031 pid and byte_cnt SHALL hold their values after the packet until the next SYNC_WAIT entry.

Reset
REQ-032 rst SHALL force IDLE immediately, including mid-packet, with rcving=0, w_enable=0, r_error=0, pid=0, byte_cnt=0 and the pending flag=0.

Structure
REQ-033 SHALL place the state enum, SYNC_BYTE and the PID width in shared package usb_rx_pkg.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 Valid packet: edge, SYNC 8'h80, PID 8'hA5, 3 data bytes, aligned EOP, edge -> 3 w_enable pulses, each 1 cycle after byte_received; pid=4'h5; byte_cnt=3; r_error=0; ends in IDLE.
REQ-036 Bad sync: first byte 8'h81 -> r_error=1 the cycle after CHK_SYNC; no w_enable; after EOP and edge, rcving=0 with r_error held.
REQ-037 Bad PID: PID 8'h55 -> ERR_WAIT, r_error=1, pid unchanged.
REQ-038 Misaligned EOP: 3 bits after a data byte then eop&shift_enable -> ERR_EOP with r_error=1.
REQ-039 Overflow: MAX_BYTES=2, send 3 data bytes -> exactly 2 w_enable pulses, then r_error=1.
REQ-040 Reset mid-packet: assert rst in RCV_BYTE -> all outputs 0 in the same cycle; the next packet is received cleanly.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: controller states, sync
// pattern and PID field width.
package usb_rx_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'h80;
    localparam int unsigned PID_W     = 4;

    typedef enum logic [3:0] {
        IDLE,
        SYNC_WAIT,
        CHK_SYNC,
        PID_WAIT,
        CHK_PID,
        RCV_BYTE,
        STORE,
        EOP_WAIT,
        ERR_WAIT,
        ERR_EOP,
        ERR_IDLE
    } rcv_state_t;

    // A PID byte carries its 4-bit value in the low nibble and the
    // one's complement of it in the high nibble.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[3:0] == ~b[7:4];
    endfunction

endpackage

// File: rtl/rcv_ctrl.sv
// USB packet receive controller: follows sync, PID and data bytes coming
// out of the shift register, strobes data bytes into the RX FIFO, and
// parks in an error path until the bus goes idle after a bad packet.
module rcv_ctrl
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic [PID_W-1:0] pid,
    output logic [6:0]       byte_cnt
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    rcv_state_t r_state;
    rcv_state_t w_next;
    logic [7:0] r_data;
    logic       r_pending;
    logic       w_eop_bit;
    logic       w_rcving;
    logic       w_err;

    assign w_eop_bit = eop && shift_enable;

    // Next-state decode plus the output values that the next state implies.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (d_edge) w_next = SYNC_WAIT;
            SYNC_WAIT: begin
                if (byte_received)  w_next = CHK_SYNC;
                else if (w_eop_bit) w_next = ERR_EOP;
            end
            CHK_SYNC:  w_next = (r_data == SYNC_BYTE) ? PID_WAIT : ERR_WAIT;
            PID_WAIT: begin
                if (byte_received)  w_next = CHK_PID;
                else if (w_eop_bit) w_next = ERR_EOP;
            end
            CHK_PID:   w_next = pid_ok(r_data) ? RCV_BYTE : ERR_WAIT;
            RCV_BYTE: begin
                if (byte_received)  w_next = (byte_cnt == MAX_CNT) ? ERR_WAIT : STORE;
                else if (w_eop_bit) w_next = r_pending ? ERR_EOP : EOP_WAIT;
            end
            STORE:     w_next = RCV_BYTE;
            EOP_WAIT:  if (d_edge) w_next = IDLE;
            ERR_WAIT:  if (w_eop_bit) w_next = ERR_EOP;
            ERR_EOP:   if (d_edge) w_next = ERR_IDLE;
            ERR_IDLE:  if (d_edge) w_next = SYNC_WAIT;
            default:   w_next = IDLE;
        endcase
        w_rcving = !((w_next == IDLE) || (w_next == ERR_IDLE));
        w_err    = (w_next == ERR_WAIT) || (w_next == ERR_EOP) || (w_next == ERR_IDLE);
    end

    // State, byte capture, pending-bit flag and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_pending <= 1'b0;
            rcving    <= 1'b0;
            w_enable  <= 1'b0;
            r_error   <= 1'b0;
            pid       <= '0;
            byte_cnt  <= '0;
        end else begin
            r_state  <= w_next;
            rcving   <= w_rcving;
            w_enable <= (w_next == STORE);
            r_error  <= w_err;
            if (byte_received) begin
                r_data <= rcv_data;
            end
            if (byte_received) begin
                r_pending <= 1'b0;
            end else if (shift_enable) begin
                r_pending <= 1'b1;
            end
            if ((w_next == SYNC_WAIT) && (r_state != SYNC_WAIT)) begin
                byte_cnt <= '0;
            end else if (w_next == STORE) begin
                byte_cnt <= byte_cnt + 7'd1;
            end
            if ((r_state == CHK_PID) && (w_next == RCV_BYTE)) begin
                pid <= r_data[PID_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_rcv_ctrl.sv
// Directed bench for rcv_ctrl: a default instance and a MAX_BYTES=2
// instance share the same stimulus.
module tb_rcv_ctrl;

    logic       clk;
    logic       rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;

    logic       rcving,  w_enable,  r_error;
    logic [3:0] pid;
    logic [6:0] byte_cnt;
    logic       rcving2, w_enable2, r_error2;
    logic [3:0] pid2;
    logic [6:0] byte_cnt2;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int wen2_cnt = 0;

    rcv_ctrl dut (
        .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .byte_received(byte_received),
        .rcv_data(rcv_data), .rcving(rcving), .w_enable(w_enable),
        .r_error(r_error), .pid(pid), .byte_cnt(byte_cnt)
    );

    rcv_ctrl #(.MAX_BYTES(2)) dut2 (
        .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .byte_received(byte_received),
        .rcv_data(rcv_data), .rcving(rcving2), .w_enable(w_enable2),
        .r_error(r_error2), .pid(pid2), .byte_cnt(byte_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count FIFO write strobes away from the active edge.
    always @(negedge clk) begin
        if (w_enable === 1'b1)  wen_cnt++;
        if (w_enable2 === 1'b1) wen2_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1; tick(); d_edge = 1'b0;
    endtask

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            shift_enable = 1'b1; tick();
            shift_enable = 1'b0; tick();
        end
    endtask

    // Eight bit strobes, then byte_received. The first check lands one cycle
    // after byte_received (STORE when a write is expected), the second after.
    task automatic send_byte(input logic [7:0] b, input logic exp_w, input logic exp_w2, input string tag);
        shift_bits(8);
        byte_received = 1'b1; rcv_data = b; tick();
        byte_received = 1'b0; rcv_data = ~b;
        checks++;
        if (w_enable !== exp_w) begin
            errors++; $display("FAIL %s_wen got %b exp %b", tag, w_enable, exp_w);
        end
        checks++;
        if (w_enable2 !== exp_w2) begin
            errors++; $display("FAIL %s_wen2 got %b exp %b", tag, w_enable2, exp_w2);
        end
        tick();
        checks++;
        if ((w_enable !== 1'b0) || (w_enable2 !== 1'b0)) begin
            errors++; $display("FAIL %s_wen_drop got %b/%b exp 0/0", tag, w_enable, w_enable2);
        end
    endtask

    task automatic aligned_eop();
        eop = 1'b1; shift_enable = 1'b1; tick();
        shift_enable = 1'b0; tick();
        eop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick();
        checks++;
        if ({rcving, w_enable, r_error, pid, byte_cnt} !== 14'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {rcving, w_enable, r_error, pid, byte_cnt});
        end
        checks++;
        if ({rcving2, w_enable2, r_error2, pid2, byte_cnt2} !== 14'd0) begin
            errors++; $display("FAIL reset_outputs2 got %h exp 0", {rcving2, w_enable2, r_error2, pid2, byte_cnt2});
        end
        rst = 1'b0; tick();
        checks++;
        if (rcving !== 1'b0) begin
            errors++; $display("FAIL idle_rcving got %b exp 0", rcving);
        end
    endtask

    task automatic test_valid_packet();
        int w0;
        w0 = wen_cnt;
        pulse_edge();
        checks++;
        if ((rcving !== 1'b1) || (byte_cnt !== 7'd0)) begin
            errors++; $display("FAIL vp_sync_entry got rcving=%b cnt=%0d exp 1/0", rcving, byte_cnt);
        end
        send_byte(8'h80, 1'b0, 1'b0, "vp_sync");
        send_byte(8'hA5, 1'b0, 1'b0, "vp_pid");
        checks++;
        if (pid !== 4'h5) begin
            errors++; $display("FAIL vp_pid got %h exp 5", pid);
        end
        send_byte(8'h11, 1'b1, 1'b1, "vp_d0");
        send_byte(8'h22, 1'b1, 1'b1, "vp_d1");
        send_byte(8'h33, 1'b1, 1'b0, "vp_d2");
        aligned_eop();
        checks++;
        if ((rcving !== 1'b1) || (r_error !== 1'b0)) begin
            errors++; $display("FAIL vp_eop_wait got rcving=%b err=%b exp 1/0", rcving, r_error);
        end
        pulse_edge(); tick();
        checks++;
        if ((rcving !== 1'b0) || (r_error !== 1'b0) || (pid !== 4'h5) || (byte_cnt !== 7'd3)) begin
            errors++; $display("FAIL vp_end got rcving=%b err=%b pid=%h cnt=%0d exp 0/0/5/3", rcving, r_error, pid, byte_cnt);
        end
        checks++;
        if (wen_cnt - w0 !== 3) begin
            errors++; $display("FAIL vp_wen_count got %0d exp 3", wen_cnt - w0);
        end
    endtask

    task automatic test_bad_pid();
        pulse_edge();
        checks++;
        if ((byte_cnt !== 7'd0) || (pid !== 4'h5)) begin
            errors++; $display("FAIL bp_entry got cnt=%0d pid=%h exp 0/5", byte_cnt, pid);
        end
        send_byte(8'h80, 1'b0, 1'b0, "bp_sync");
        send_byte(8'h55, 1'b0, 1'b0, "bp_pid");
        checks++;
        if ((r_error !== 1'b1) || (rcving !== 1'b1) || (pid !== 4'h5)) begin
            errors++; $display("FAIL bp_err got err=%b rcving=%b pid=%h exp 1/1/5", r_error, rcving, pid);
        end
    endtask

    task automatic test_bad_sync();
        int w0;
        w0 = wen_cnt;
        pulse_edge();
        send_byte(8'h81, 1'b0, 1'b0, "bs_sync");
        checks++;
        if ((r_error !== 1'b1) || (rcving !== 1'b1)) begin
            errors++; $display("FAIL bs_err got err=%b rcving=%b exp 1/1", r_error, rcving);
        end
        aligned_eop();
        pulse_edge(); tick();
        checks++;
        if ((rcving !== 1'b0) || (r_error !== 1'b1)) begin
            errors++; $display("FAIL bs_err_idle got rcving=%b err=%b exp 0/1", rcving, r_error);
        end
        checks++;
        if (wen_cnt - w0 !== 0) begin
            errors++; $display("FAIL bs_wen_count got %0d exp 0", wen_cnt - w0);
        end
        pulse_edge();
        checks++;
        if ((rcving !== 1'b1) || (r_error !== 1'b0) || (byte_cnt !== 7'd0)) begin
            errors++; $display("FAIL bs_restart got rcving=%b err=%b cnt=%0d exp 1/0/0", rcving, r_error, byte_cnt);
        end
    endtask

    task automatic test_misaligned_eop();
        pulse_edge();
        send_byte(8'h80, 1'b0, 1'b0, "me_sync");
        send_byte(8'hA5, 1'b0, 1'b0, "me_pid");
        send_byte(8'h5A, 1'b1, 1'b1, "me_d0");
        shift_bits(3);
        checks++;
        if (r_error !== 1'b0) begin
            errors++; $display("FAIL me_pre got err=%b exp 0", r_error);
        end
        aligned_eop();
        checks++;
        if ((r_error !== 1'b1) || (rcving !== 1'b1)) begin
            errors++; $display("FAIL me_err_eop got err=%b rcving=%b exp 1/1", r_error, rcving);
        end
        pulse_edge();
        checks++;
        if ((rcving !== 1'b0) || (r_error !== 1'b1)) begin
            errors++; $display("FAIL me_err_idle got rcving=%b err=%b exp 0/1", rcving, r_error);
        end
    endtask

    task automatic test_overflow();
        int w0;
        w0 = wen2_cnt;
        pulse_edge();
        send_byte(8'h80, 1'b0, 1'b0, "ov_sync");
        send_byte(8'hA5, 1'b0, 1'b0, "ov_pid");
        send_byte(8'h01, 1'b1, 1'b1, "ov_d0");
        send_byte(8'h02, 1'b1, 1'b1, "ov_d1");
        checks++;
        if ((byte_cnt2 !== 7'd2) || (r_error2 !== 1'b0)) begin
            errors++; $display("FAIL ov_full got cnt=%0d err=%b exp 2/0", byte_cnt2, r_error2);
        end
        send_byte(8'h03, 1'b1, 1'b0, "ov_d2");
        checks++;
        if ((r_error2 !== 1'b1) || (byte_cnt2 !== 7'd2) || (wen2_cnt - w0 !== 2)) begin
            errors++; $display("FAIL ov_err got err=%b cnt=%0d wen=%0d exp 1/2/2", r_error2, byte_cnt2, wen2_cnt - w0);
        end
        checks++;
        if ((r_error !== 1'b0) || (byte_cnt !== 7'd3)) begin
            errors++; $display("FAIL ov_default got err=%b cnt=%0d exp 0/3", r_error, byte_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        int w0;
        pulse_edge();
        send_byte(8'h80, 1'b0, 1'b0, "rm_sync");
        send_byte(8'hA5, 1'b0, 1'b0, "rm_pid");
        send_byte(8'h77, 1'b1, 1'b1, "rm_d0");
        shift_bits(3);
        rst = 1'b1; #1;
        checks++;
        if ({rcving, w_enable, r_error, pid, byte_cnt} !== 14'd0) begin
            errors++; $display("FAIL rm_async got %h exp 0", {rcving, w_enable, r_error, pid, byte_cnt});
        end
        tick(); rst = 1'b0; tick();
        w0 = wen_cnt;
        pulse_edge();
        send_byte(8'h80, 1'b0, 1'b0, "rm2_sync");
        send_byte(8'hC3, 1'b0, 1'b0, "rm2_pid");
        send_byte(8'hAA, 1'b1, 1'b1, "rm2_d0");
        // Bus edge while receiving data must not disturb the packet.
        pulse_edge(); tick();
        checks++;
        if ((rcving !== 1'b1) || (r_error !== 1'b0)) begin
            errors++; $display("FAIL rm2_edge_ignored got rcving=%b err=%b exp 1/0", rcving, r_error);
        end
        send_byte(8'hBB, 1'b1, 1'b1, "rm2_d1");
        aligned_eop();
        pulse_edge(); tick();
        checks++;
        if ((rcving !== 1'b0) || (r_error !== 1'b0) || (pid !== 4'h3) || (byte_cnt !== 7'd2) || (wen_cnt - w0 !== 2)) begin
            errors++; $display("FAIL rm2_end got rcving=%b err=%b pid=%h cnt=%0d wen=%0d exp 0/0/3/2/2",
                               rcving, r_error, pid, byte_cnt, wen_cnt - w0);
        end
    endtask

    initial begin
        rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
        byte_received = 1'b0; rcv_data = 8'h00;
        test_reset();
        test_valid_packet();
        test_bad_pid();
        test_reset();
        test_bad_sync();
        test_reset();
        test_misaligned_eop();
        test_reset();
        test_overflow();
        test_reset();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
